// File: rtl/fifo_wrapper_pkg.sv
// Sizing helpers shared by the FIFO wrapper and its storage array.
// Pointer width stays at least 1 bit so tiny configurations still elaborate.
package fifo_wrapper_pkg;

   function automatic int addr_bits(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic int occ_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for fifo_wrapper: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem
   import fifo_wrapper_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 128
)
(
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [addr_bits(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [addr_bits(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]           rd_data
);

   logic [WIDTH-1:0] mem_array [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_array[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/fifo_wrapper.sv
// First-word-fall-through FIFO with registered input_ready and async active-low reset.
// Define FIFO_WRAPPER_LEVEL_EN to expose the registered occupancy on port 'level'.
module fifo_wrapper
   import fifo_wrapper_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 128
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           input_data,
   input  logic                       input_valid,
   output logic                       input_ready,
   output logic [WIDTH-1:0]           output_data,
   output logic                       output_valid,
`ifdef FIFO_WRAPPER_LEVEL_EN
   output logic [occ_bits(DEPTH)-1:0] level,
`endif
   input  logic                       output_ready
);

   localparam int AW = addr_bits(DEPTH);
   localparam int CW = occ_bits(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          ready_q;
   logic          do_write;
   logic          do_pop;

   // Every flag is derived from registers only, so no input reaches an output combinationally.
   assign output_valid = (count != '0);
   assign input_ready  = ready_q;
   assign do_write     = input_valid & ready_q;
   assign do_pop       = output_valid & output_ready;

   always_comb begin
      count_next = count;
      case ({do_write, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         if (do_write) begin
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
         end
         count   <= count_next;
         ready_q <= (count_next < FULL_COUNT);
      end
   end

`ifdef FIFO_WRAPPER_LEVEL_EN
   assign level = count;
`endif

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (do_write),
      .wr_addr (wr_ptr),
      .wr_data (input_data),
      .rd_addr (rd_ptr),
      .rd_data (output_data)
   );

endmodule

// File: tb/tb_fifo_wrapper.sv
// Self-checking bench for fifo_wrapper against a queue-based reference model.
// Covers reset, single word, fill/drain, streaming, mid-operation reset and random traffic.
module tb_fifo_wrapper;

   localparam int WIDTH = 8;
   localparam int DEPTH = 128;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] input_data;
   logic             input_valid;
   logic             input_ready;
   logic [WIDTH-1:0] output_data;
   logic             output_valid;
   logic             output_ready;
`ifdef FIFO_WRAPPER_LEVEL_EN
   logic [CW-1:0]    level;
`endif

   int vectors;
   int miscompares;

   logic [WIDTH-1:0] model_q[$];
   logic             exp_ready;

   fifo_wrapper #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .input_data   (input_data),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .output_data  (output_data),
      .output_valid (output_valid),
`ifdef FIFO_WRAPPER_LEVEL_EN
      .level        (level),
`endif
      .output_ready (output_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compares every visible output against the model state for the current cycle.
   task automatic checkModel();
      checkOutput("output_valid", output_valid, (model_q.size() != 0));
      checkOutput("input_ready", input_ready, exp_ready);
      if (model_q.size() != 0) begin
         checkOutput("output_data", output_data, model_q[0]);
      end
`ifdef FIFO_WRAPPER_LEVEL_EN
      checkOutput("level", level, model_q.size());
`endif
   endtask

   // Drives one cycle of stimulus, checks pre-edge outputs, then advances the model.
   task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
      logic accept;
      logic pop;
      input_valid  = iv;
      input_data   = d;
      output_ready = ordy;
      #1;
      checkModel();
      accept = iv && exp_ready;
      pop    = ordy && (model_q.size() != 0);
      @(posedge clk);
      if (pop) begin
         void'(model_q.pop_front());
      end
      if (accept) begin
         model_q.push_back(d);
      end
      exp_ready = (model_q.size() < DEPTH);
      #1;
   endtask

   task automatic applyReset(input int cycles);
      reset        = 1'b0;
      input_valid  = 1'b0;
      output_ready = 1'b0;
      #1;
      model_q.delete();
      exp_ready = 1'b0;
      checkOutput("rst_ready", input_ready, 1'b0);
      checkOutput("rst_valid", output_valid, 1'b0);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         checkOutput("rst_ready_hold", input_ready, 1'b0);
         checkOutput("rst_valid_hold", output_valid, 1'b0);
      end
      reset = 1'b1;
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      int pw;
      int pr;
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b0;
      input_valid  = 1'b0;
      input_data   = '0;
      output_ready = 1'b0;
      exp_ready    = 1'b0;

      applyReset(3);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("ready_after_release", input_ready, 1'b1);
      checkOutput("valid_after_release", output_valid, 1'b0);

      applyStimulus(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("single_hold_valid", output_valid, 1'b1);
         checkOutput("single_hold_data", output_data, 8'hA5);
         applyStimulus(1'b0, 8'h00, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("single_popped", output_valid, 1'b0);

      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, WIDTH'(i), 1'b0);
      end
      checkOutput("full_ready", input_ready, 1'b0);
`ifdef FIFO_WRAPPER_LEVEL_EN
      checkOutput("full_level", level, DEPTH);
`endif
      applyStimulus(1'b1, 8'hFF, 1'b0);
      checkOutput("full_still_not_ready", input_ready, 1'b0);

      for (int i = 0; i < DEPTH; i++) begin
         checkOutput("drain_order", output_data, WIDTH'(i));
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkOutput("drain_empty", output_valid, 1'b0);
      checkOutput("drain_ready", input_ready, 1'b1);

      d = 8'h00;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, d, 1'b0);
         d++;
      end
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, d, 1'b1);
         d++;
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
      end

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, WIDTH'(8'h50 + i), 1'b0);
      end
      reset       = 1'b0;
      input_valid = 1'b1;
      input_data  = 8'hEE;
      #1;
      model_q.delete();
      exp_ready = 1'b0;
      checkOutput("midrst_valid", output_valid, 1'b0);
      checkOutput("midrst_ready", input_ready, 1'b0);
      @(posedge clk);
      #1;
      reset       = 1'b1;
      input_valid = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h3C, 1'b0);
      checkOutput("first_after_rst", output_data, 8'h3C);
      applyStimulus(1'b1, 8'h3D, 1'b1);
      checkOutput("second_after_rst", output_data, 8'h3D);

      // Vary write/read bias so random traffic visits both full and empty.
      for (int blk = 0; blk < 4; blk++) begin
         pw = (blk % 2 == 0) ? 80 : 30;
         pr = (blk % 2 == 0) ? 30 : 80;
         for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 99) < pw), WIDTH'($urandom), ($urandom_range(0, 99) < pr));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wrapper.md
FIFO_WRAPPER -- requirements
Module: fifo_wrapper

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 128: number of storage entries, legal range 2 or more, power of two not required.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port input_data, input, WIDTH bits: write word.
REQ-006 SHALL have port input_valid, input, 1 bit: producer offers input_data.
REQ-007 SHALL have port input_ready, output, 1 bit: FIFO can accept a word.
REQ-008 SHALL have port output_data, output, WIDTH bits: head-of-queue word.
REQ-009 SHALL have port output_valid, output, 1 bit: output_data holds a valid word.
REQ-010 SHALL have port output_ready, input, 1 bit: consumer takes the word.

Function
REQ-011 SHALL accept (write) a word on a clk edge exactly when input_valid and input_ready are both 1.
REQ-012 SHALL pop a word on a clk edge exactly when output_valid and output_ready are both 1.
REQ-013 SHALL be first-word-fall-through:
- output_data equals the oldest stored word whenever output_valid is 1.
- Write-to-output_valid latency is 1 cycle from the accepting edge when empty.
REQ-014 SHALL register input_ready, with no combinational path from any input to input_ready, output_valid or output_data.
REQ-015 SHALL compute input_ready as "occupancy after this edge is below DEPTH".
REQ-016 SHALL drive output_valid = occupancy is not 0.
REQ-017 SHALL preserve words in order, with no loss and no duplication.
REQ-018 SHALL hold output_data and output_valid stable while output_valid is 1 and output_ready is 0.
REQ-019 SHALL keep occupancy unchanged on a simultaneous write and pop, with both pointers advancing, including at occupancy 1 and at DEPTH-1.
REQ-020 SHALL, when full, keep input_ready at 0; a pop in that cycle raises input_ready on the following cycle.
REQ-021 SHALL, when empty, keep output_valid at 0 and ignore output_ready.
REQ-022 SHALL wrap the read and write pointers from DEPTH-1 to 0.
REQ-023 SHALL size the occupancy counter to $clog2(DEPTH+1) bits.

Reset
REQ-024 SHALL, while reset is 0, immediately force:
- occupancy 0 and both pointers 0;
- output_valid 0;
- input_ready 0.
REQ-025 SHALL leave storage contents unreset; output_data is don't-care while output_valid is 0.
REQ-026 SHALL raise input_ready on the first clk edge after reset returns to 1.
REQ-027 SHALL discard all contents on a reset asserted mid-operation, with no partial write completing.

Configuration
REQ-028 SHALL, with macro FIFO_WRAPPER_LEVEL_EN defined, add output port level, $clog2(DEPTH+1) bits, equal to current occupancy (reset value 0, registered).
REQ-029 SHALL, without FIFO_WRAPPER_LEVEL_EN, have no level port and unchanged behaviour otherwise.

Structure
REQ-030 SHALL need no shared-package typedefs; decoder message constants (for example START_DECODING_MSG, MEASUREMENT_DATA_HEADER) stay in the decoder parameter package, not in this block.
REQ-031 SHALL place storage in one sub-module fifo_mem:
- simple dual-port array, DEPTH x WIDTH;
- synchronous write port, asynchronous read port.
REQ-032 SHALL keep pointer, occupancy and flag logic in fifo_wrapper.

Verification
REQ-033 Bench SHALL cover reset release: reset 0 for 3 cycles then 1 -> input_ready 0 during reset, 1 after first edge; output_valid 0 throughout.
REQ-034 Bench SHALL cover single word: write 8'hA5 with output_ready 0 -> output_valid 1 next cycle with output_data 8'hA5, held 5 cycles; then output_ready 1 -> popped, output_valid 0.
REQ-035 Bench SHALL cover fill to full: DEPTH=128, output_ready 0, write 0..127 -> input_ready 0 after the 128th accept; 129th offer not accepted; level=128 if enabled.
REQ-036 Bench SHALL cover drain: pop all 128 -> data 0..127 in order, output_valid 0 afterwards, input_ready 1.
REQ-037 Bench SHALL cover concurrent streaming: input_valid and output_ready both 1 for 300 cycles with incrementing data -> occupancy constant, pointer wrap exercised, output sequence equals input sequence.
REQ-038 Bench SHALL cover mid-operation reset: 10 words stored, reset pulsed 0 for 1 cycle -> output_valid 0 at once; after release, first word out is the first new word written.
